// File: rtl/cache_lsu_initiator.sv
// Single-outstanding load/store initiator for the CacheTop word port (ADDR/DIN/WE, DOUT/RDY).
// Optional WAIT-state timeout is compiled in with `define LSU_TIMEOUT_EN.
module cache_lsu_initiator #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic          REQ_WE,
    input  logic [AW-1:0] REQ_ADDR,
    input  logic [DW-1:0] REQ_WDATA,
    output logic          RSP_VALID,
    input  logic          RSP_READY,
    output logic [DW-1:0] RSP_RDATA,
    output logic          RSP_ERR,
    output logic [AW-1:0] C_ADDR,
    output logic [DW-1:0] C_DIN,
    output logic          C_WE,
    input  logic [DW-1:0] C_DOUT,
    input  logic          C_RDY
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] c_addr_q, c_addr_d;
    logic [DW-1:0] c_din_q, c_din_d;
    logic          c_we_q, c_we_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rsp_err_q, rsp_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        c_addr_d    = c_addr_q;
        c_din_d     = c_din_q;
        c_we_d      = c_we_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    c_addr_d = REQ_ADDR;
                    c_din_d  = REQ_WDATA;
                    c_we_d   = REQ_WE;
                    state_d  = S_ISSUE;
                end
            end
            // RDY seen here still belongs to the previous access.
            S_ISSUE: begin
                c_we_d  = 1'b0;
                state_d = S_WAIT;
`ifdef LSU_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (C_RDY) begin
                    rsp_rdata_d = C_DOUT;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
`ifdef LSU_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            S_RESP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            c_addr_q    <= '0;
            c_din_q     <= '0;
            c_we_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            c_addr_q    <= c_addr_d;
            c_din_q     <= c_din_d;
            c_we_q      <= c_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign REQ_READY = (state_q == S_IDLE) && !RST;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign C_ADDR    = c_addr_q;
    assign C_DIN     = c_din_q;
    assign C_WE      = c_we_q;

`ifdef LSU_TIMEOUT_EN
    assign RSP_ERR = rsp_err_q;
`else
    // Without the timeout the limit has no effect; keep it referenced.
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES >= 1);
    assign RSP_ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_cache_lsu_initiator.sv
// Randomized bench for cache_lsu_initiator: cycle-level cache model plus a word-array reference.
module tb_cache_lsu_initiator;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef LSU_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 255;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          REQ_VALID = 1'b0;
    logic          REQ_READY;
    logic          REQ_WE = 1'b0;
    logic [AW-1:0] REQ_ADDR = '0;
    logic [DW-1:0] REQ_WDATA = '0;
    logic          RSP_VALID;
    logic          RSP_READY = 1'b0;
    logic [DW-1:0] RSP_RDATA;
    logic          RSP_ERR;
    logic [AW-1:0] C_ADDR;
    logic [DW-1:0] C_DIN;
    logic          C_WE;
    logic [DW-1:0] C_DOUT;
    logic          C_RDY;

    int passed = 0;
    int total  = 0;

    always #5 CLK = ~CLK;

    cache_lsu_initiator #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .C_ADDR(C_ADDR), .C_DIN(C_DIN), .C_WE(C_WE), .C_DOUT(C_DOUT), .C_RDY(C_RDY)
    );

    // Cycle counter and port monitors, sampled on the active edge (pre-update values).
    int            cyc = 0;
    int            we_cnt = 0;
    int            hs_cnt = 0;
    logic [AW-1:0] we_addr = '0;
    logic [DW-1:0] we_din = '0;
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (C_WE) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= C_ADDR;
            we_din  <= C_DIN;
        end
        if (RSP_VALID && RSP_READY) hs_cnt <= hs_cnt + 1;
    end

    // Cache model: hit -> RDY on the first cycle after the access is seen, miss -> RDY 8 cycles later.
    logic [31:0]   seed = 32'h0;
    logic [DW-1:0] cmem [64];
    bit            cwritten [64];
    bit            cached [64];
    bit            stall = 1'b0;
    logic [AW-1:0] prev_addr;
    int            mcnt;
    logic [DW-1:0] c_dout_m;
    logic          c_rdy_m;
    assign C_DOUT = c_dout_m;
    assign C_RDY  = c_rdy_m;

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h9E3779B1) ^ seed;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            c_rdy_m   <= 1'b0;
            c_dout_m  <= '0;
            mcnt      <= 0;
            prev_addr <= '1;
        end else begin
            prev_addr <= C_ADDR;
            if (C_ADDR != prev_addr || C_WE) begin
                if (C_WE) begin
                    cmem[C_ADDR[5:0]]     <= C_DIN;
                    cwritten[C_ADDR[5:0]] <= 1'b1;
                end
                c_dout_m <= C_WE ? C_DIN :
                            (cwritten[C_ADDR[5:0]] ? cmem[C_ADDR[5:0]] : init_word(int'(C_ADDR[5:0])));
                if (cached[C_ADDR[5:0]]) begin
                    c_rdy_m <= !stall;
                    mcnt    <= 0;
                end else begin
                    c_rdy_m <= 1'b0;
                    mcnt    <= 7;
                    cached[C_ADDR[5:0]] <= 1'b1;
                end
            end else if (mcnt != 0) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1) c_rdy_m <= !stall;
            end else if (stall) begin
                c_rdy_m <= 1'b0;
            end
        end
    end

    // Reference: plain word array plus the set of addresses already accessed (those must hit).
    logic [DW-1:0] exp_mem [64];
    bit            touched [64];

    task automatic txn(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       output logic [DW-1:0] rd, output logic er, output int lat, output bit got);
        int n;
        int acc;
        got = 1'b0; rd = '0; er = 1'b0; lat = -1;
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = addr; REQ_WDATA = wd;
        n = 0;
        while (!REQ_READY && n < 50) begin @(negedge CLK); n++; end
        if (!REQ_READY) begin REQ_VALID = 1'b0; return; end
        acc = cyc;
        @(negedge CLK);
        REQ_VALID = 1'b0; REQ_WE = 1'($urandom); REQ_ADDR = $urandom; REQ_WDATA = $urandom;
        n = 0;
        while (!RSP_VALID && n < 100) begin @(negedge CLK); n++; end
        if (!RSP_VALID) return;
        got = 1'b1; lat = cyc - acc; rd = RSP_RDATA; er = RSP_ERR;
        RSP_READY = 1'b1;
        @(negedge CLK);
        RSP_READY = 1'b0;
    endtask

    task automatic test_reset();
        repeat (10) @(negedge CLK);
        total++; if (C_WE !== 1'b0) $display("FAIL reset_c_we: got %b want 0", C_WE); else passed++;
        total++; if (RSP_VALID !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", RSP_VALID); else passed++;
        total++; if (REQ_READY !== 1'b0) $display("FAIL reset_req_ready: got %b want 0", REQ_READY); else passed++;
        total++; if (C_ADDR !== '0) $display("FAIL reset_c_addr: got %h want 0", C_ADDR); else passed++;
        total++; if (RSP_ERR !== 1'b0 || RSP_RDATA !== '0)
            $display("FAIL reset_rsp: got err=%b rdata=%h want 0/0", RSP_ERR, RSP_RDATA); else passed++;
        RST = 1'b0;
        #1;
        total++; if (REQ_READY !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", REQ_READY); else passed++;
    endtask

    task automatic test_store_load();
        logic [DW-1:0] rd; logic er; int lat; bit got; int w0;
        w0 = we_cnt;
        txn(1'b1, 22, 32'hFFFFE8CA, rd, er, lat, got);
        exp_mem[22] = 32'hFFFFE8CA; touched[22] = 1'b1;
        total++; if (!got) $display("FAIL store_rsp: no response"); else passed++;
        total++; if (we_cnt - w0 !== 1) $display("FAIL store_we_cycles: got %0d want 1", we_cnt - w0); else passed++;
        total++; if (we_addr !== 22 || we_din !== 32'hFFFFE8CA)
            $display("FAIL store_port: got addr=%0d din=%h want 22/ffffe8ca", we_addr, we_din); else passed++;
        total++; if (rd !== 32'hFFFFE8CA || er !== 1'b0)
            $display("FAIL store_readback: got %h err=%b want ffffe8ca/0", rd, er); else passed++;
        w0 = we_cnt;
        txn(1'b0, 22, $urandom, rd, er, lat, got);
        total++; if (!got || rd !== 32'hFFFFE8CA || er !== 1'b0)
            $display("FAIL load22: got %h err=%b rsp=%b want ffffe8ca/0/1", rd, er, got); else passed++;
        total++; if (we_cnt !== w0) $display("FAIL load_we: got %0d pulses want 0", we_cnt - w0); else passed++;
    endtask

    task automatic test_load_sweep();
        logic [DW-1:0] rd; logic er; int lat; bit got; int a; bit hit;
        for (int k = 0; k < 40; k++) begin
            a   = (k < 20) ? k : int'($urandom_range(0, 19));
            hit = touched[a];
            txn(1'b0, AW'(a), $urandom, rd, er, lat, got);
            touched[a] = 1'b1;
            total++; if (!got || rd !== exp_mem[a] || er !== 1'b0)
                $display("FAIL sweep_load[%0d]: got %h err=%b rsp=%b want %h", a, rd, er, got, exp_mem[a]);
            else passed++;
            if (hit) begin
                total++; if (lat !== 3) $display("FAIL sweep_hit_lat[%0d]: got %0d want 3", a, lat); else passed++;
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] rd, wd, want; logic er; int lat; bit got, we, hit; int a;
        for (int k = 0; k < 30; k++) begin
            we = 1'($urandom); a = int'($urandom_range(0, 31)); wd = $urandom;
            hit = touched[a];
            want = we ? wd : exp_mem[a];
            txn(we, AW'(a), wd, rd, er, lat, got);
            if (we) exp_mem[a] = wd;
            touched[a] = 1'b1;
            total++; if (!got || rd !== want || er !== 1'b0)
                $display("FAIL rand[%0d] we=%b a=%0d: got %h err=%b want %h", k, we, a, rd, er, want);
            else passed++;
            if (hit && !we) begin
                total++; if (lat !== 3) $display("FAIL rand_hit_lat[%0d]: got %0d want 3", k, lat); else passed++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d0; int n; int hs0; bit bad;
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 3;
        n = 0;
        while (!REQ_READY && n < 50) begin @(negedge CLK); n++; end
        @(negedge CLK);
        REQ_VALID = 1'b0;
        n = 0;
        while (!RSP_VALID && n < 100) begin @(negedge CLK); n++; end
        d0 = RSP_RDATA; hs0 = hs_cnt; bad = 1'b0;
        total++; if (RSP_VALID !== 1'b1 || d0 !== exp_mem[3])
            $display("FAIL bp_first: got valid=%b data=%h want 1/%h", RSP_VALID, d0, exp_mem[3]); else passed++;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (RSP_VALID !== 1'b1 || RSP_RDATA !== d0 || REQ_READY !== 1'b0) bad = 1'b1;
        end
        total++; if (bad) $display("FAIL bp_hold: got valid=%b data=%h ready=%b want 1/%h/0",
                                   RSP_VALID, RSP_RDATA, REQ_READY, d0); else passed++;
        RSP_READY = 1'b1;
        @(negedge CLK);
        RSP_READY = 1'b0;
        repeat (3) @(negedge CLK);
        total++; if (hs_cnt - hs0 !== 1) $display("FAIL bp_handshakes: got %0d want 1", hs_cnt - hs0); else passed++;
        total++; if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1)
            $display("FAIL bp_release: got valid=%b ready=%b want 0/1", RSP_VALID, REQ_READY); else passed++;
    endtask

    task automatic test_reset_midop();
        logic [DW-1:0] rd; logic er; int lat; bit got; int n; int seen;
        @(negedge CLK); stall = 1'b1;
        // Reset while the write pulse is on the port.
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 6; REQ_WDATA = $urandom;
        n = 0;
        while (!REQ_READY && n < 50) begin @(negedge CLK); n++; end
        @(negedge CLK); REQ_VALID = 1'b0;
        total++; if (C_WE !== 1'b1) $display("FAIL issue_we: got %b want 1", C_WE); else passed++;
        #2 RST = 1'b1;
        #1;
        total++; if (C_WE !== 1'b0 || REQ_READY !== 1'b0 || RSP_VALID !== 1'b0)
            $display("FAIL rst_in_issue: got we=%b ready=%b valid=%b want 0/0/0", C_WE, REQ_READY, RSP_VALID);
        else passed++;
        @(negedge CLK); RST = 1'b0;
        // Reset while waiting on RDY.
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 5; REQ_WDATA = $urandom;
        n = 0;
        while (!REQ_READY && n < 50) begin @(negedge CLK); n++; end
        @(negedge CLK); REQ_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        total++; if (C_WE !== 1'b0 || RSP_VALID !== 1'b0 || C_ADDR !== '0)
            $display("FAIL rst_in_wait: got we=%b valid=%b addr=%h want 0/0/0", C_WE, RSP_VALID, C_ADDR);
        else passed++;
        repeat (2) @(negedge CLK);
        stall = 1'b0; RST = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin @(negedge CLK); if (RSP_VALID) seen++; end
        total++; if (seen != 0) $display("FAIL dropped_rsp: got %0d valid cycles want 0", seen); else passed++;
        txn(1'b0, 0, $urandom, rd, er, lat, got);
        total++; if (!got || rd !== exp_mem[0] || er !== 1'b0)
            $display("FAIL load0_after_rst: got %h err=%b rsp=%b want %h", rd, er, got, exp_mem[0]); else passed++;
    endtask

    task automatic test_timeout();
        @(negedge CLK); stall = 1'b1;
`ifdef LSU_TIMEOUT_EN
        begin
            logic [DW-1:0] rd; logic er; int lat; bit got;
            txn(1'b0, 40, $urandom, rd, er, lat, got);
            total++; if (!got || lat !== TO + 2)
                $display("FAIL timeout_lat: got %0d rsp=%b want %0d", lat, got, TO + 2); else passed++;
            total++; if (rd !== '0 || er !== 1'b1)
                $display("FAIL timeout_rsp: got %h err=%b want 0/1", rd, er); else passed++;
        end
`else
        begin
            int n; int seen;
            @(negedge CLK);
            REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 40;
            n = 0;
            while (!REQ_READY && n < 50) begin @(negedge CLK); n++; end
            @(negedge CLK); REQ_VALID = 1'b0;
            seen = 0;
            for (int i = 0; i < 1000; i++) begin @(negedge CLK); if (RSP_VALID) seen++; end
            total++; if (seen != 0 || RSP_ERR !== 1'b0)
                $display("FAIL no_timeout: got %0d valid cycles err=%b want 0/0", seen, RSP_ERR); else passed++;
            RST = 1'b1;
            @(negedge CLK); RST = 1'b0;
        end
`endif
        stall = 1'b0;
    endtask

    initial begin
        seed = $urandom;
        for (int i = 0; i < 64; i++) exp_mem[i] = init_word(i);
        test_reset();
        test_store_load();
        test_load_sweep();
        test_random();
        test_backpressure();
        test_reset_midop();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
